clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_S, default 10, sets the seconds of button inactivity before set mode exits automatically (legal range 1..255).
REQ-002 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 event_clk1s  input  1  one-cycle pulse, once per second.
REQ-005 btn_mode  input  1  debounced one-cycle pulse: enter set mode or advance to the next field.
REQ-006 btn_ok  input  1  debounced one-cycle pulse: leave set mode immediately.
REQ-007 btn_up  input  1  debounced one-cycle pulse: increment the selected field.
REQ-008 btn_down  input  1  debounced one-cycle pulse: decrement the selected field.
REQ-009 set_mode  output  1  high in any SET state; the timekeeping datapath holds its count while high.
REQ-010 field_sel  output  3  selected field: 0 RUN, 1 SEC, 2 MIN, 3 HOUR, 4 DAY, 5 MON, 6 YEAR; 7 is never driven.
REQ-011 inc_pulse  output  1  one-cycle increment command for the selected field.
REQ-012 dec_pulse  output  1  one-cycle decrement command for the selected field.
REQ-013 blank  output  1  when high, the digits of the selected field are blanked; always low in RUN.

Function
REQ-014 The FSM SHALL have states RUN, SET_SEC, SET_MIN, SET_HOUR, SET_DAY, SET_MON and SET_YEAR; field_sel and set_mode SHALL be registered state decodes.
REQ-015 btn_mode in RUN SHALL go to SET_SEC, and the state SHALL be visible on the outputs in the next cycle.
REQ-016 btn_mode SHALL advance SEC -> MIN -> HOUR -> DAY -> MON -> YEAR -> RUN, one step per pulse.
REQ-017 btn_ok in any SET state SHALL go to RUN; in RUN it SHALL have no effect.
REQ-018 Priority, highest first: btn_ok, btn_mode, then btn_up/btn_down; a lower-priority button in the same cycle SHALL be ignored.
REQ-019 In a SET state, btn_up alone SHALL give inc_pulse high for exactly the next cycle; btn_down alone SHALL give dec_pulse likewise.
REQ-020 btn_up and btn_down in the same cycle SHALL produce no pulse.
REQ-021 inc_pulse and dec_pulse SHALL never be high in RUN, and never both high at once.
REQ-022 The blink phase register SHALL toggle on each event_clk1s while in a SET state, so each field is 1 s visible and 1 s blank.
REQ-023 Entering any SET state, or any accepted up/down press, SHALL force blank low in the next cycle, so the field is visible while it is being edited.
REQ-024 blank SHALL be forced low in RUN.
REQ-025 If event_clk1s coincides with a state entry or an accepted press, the forced-visible rule SHALL win.
REQ-026 Every cycle SHALL take exactly one of these branches, in priority order, with no intermediate or glitch state:
- state change: apply the FSM transition;
- accepted up/down press: issue the pulse;
- neither: keep state and outputs.

Reset
REQ-027 With rst high at a clock edge, the state SHALL be RUN, set_mode 0, field_sel 0, inc_pulse 0, dec_pulse 0, blank 0, blink phase visible, and timeout counter 0.
REQ-028 rst asserted mid-edit SHALL abandon set mode with no pending pulse issued.
REQ-029 rst SHALL take priority over every input in the same cycle.

Configuration
REQ-030 Macro CLOCK_SET_TIMEOUT_EN, when defined, SHALL compile in an 8-bit inactivity counter.
- Counts event_clk1s pulses while in a SET state.
- Clears on any button pulse, on state entry, and in RUN.
- Reaching TIMEOUT_S forces RUN on the cycle of the terminal event_clk1s.
- A button pulse in that same cycle takes precedence: the counter clears and no timeout occurs.
REQ-031 Without CLOCK_SET_TIMEOUT_EN, no counter SHALL exist and set mode SHALL be left only via btn_mode from YEAR, btn_ok, or rst.

Verification
REQ-032 Reset, then btn_mode x1 -> next cycle field_sel=1, set_mode=1, blank=0; then btn_mode x6 more -> field_sel returns to 0, set_mode=0.
REQ-033 In SET_MIN, btn_up then btn_down 3 cycles apart -> inc_pulse and dec_pulse are each high exactly 1 cycle; btn_up and btn_down together -> neither pulse.
REQ-034 In SET_HOUR, 3 event_clk1s pulses -> blank sequence 1,0,1; btn_up on the 3rd pulse's cycle -> blank=0 and inc_pulse=1.
REQ-035 btn_ok together with btn_up in SET_DAY -> next cycle RUN and inc_pulse=0; btn_up in RUN -> no pulse.
REQ-036 With CLOCK_SET_TIMEOUT_EN and TIMEOUT_S=3, 3 event_clk1s pulses in SET_YEAR with no button -> RUN after the 3rd; a repeat with btn_up on the 2nd pulse -> still SET_YEAR after 4 pulses. Without the macro, 300 pulses -> still SET_YEAR.
REQ-037 rst pulsed while in SET_MON with btn_up asserted -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a real-time clock: walks the editable fields, issues inc/dec
// commands and blinks the selected field. Optional inactivity timeout: CLOCK_SET_TIMEOUT_EN.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       event_clk1s,
  input  logic       btn_mode,
  input  logic       btn_ok,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       set_mode,
  output logic [2:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blank
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_SEC  = 3'd1,
    SET_MIN  = 3'd2,
    SET_HOUR = 3'd3,
    SET_DAY  = 3'd4,
    SET_MON  = 3'd5,
    SET_YEAR = 3'd6
  } state_t;

  state_t state;
  state_t nxt;
  logic   change;
  logic   in_set;
  logic   any_btn;
  logic   press_up;
  logic   press_dn;
  logic   timeout;

  assign in_set   = (state != RUN);
  assign any_btn  = btn_mode | btn_ok | btn_up | btn_down;
  // up/down are only accepted alone and when no higher-priority button is present
  assign press_up = in_set & btn_up & ~btn_down & ~btn_ok & ~btn_mode;
  assign press_dn = in_set & btn_down & ~btn_up & ~btn_ok & ~btn_mode;

  // field_sel is the state register itself, so it is registered by construction
  assign field_sel = 3'(state);

`ifdef CLOCK_SET_TIMEOUT_EN
  logic [7:0] idle_cnt;

  assign timeout = in_set & event_clk1s & ~any_btn &
                   (idle_cnt == 8'(TIMEOUT_S - 1));

  // Idle seconds in set mode; any button or state change restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 8'd0;
    end else if (!in_set || change || any_btn) begin
      idle_cnt <= 8'd0;
    end else if (event_clk1s) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^8'(TIMEOUT_S);
`endif

  // Transition decision in priority order: ok, mode, timeout
  always_comb begin
    nxt    = state;
    change = 1'b0;
    if (btn_ok) begin
      if (in_set) begin
        nxt    = RUN;
        change = 1'b1;
      end
    end else if (btn_mode) begin
      change = 1'b1;
      case (state)
        RUN:      nxt = SET_SEC;
        SET_SEC:  nxt = SET_MIN;
        SET_MIN:  nxt = SET_HOUR;
        SET_HOUR: nxt = SET_DAY;
        SET_DAY:  nxt = SET_MON;
        SET_MON:  nxt = SET_YEAR;
        SET_YEAR: nxt = RUN;
        default:  nxt = RUN;
      endcase
    end else if (timeout) begin
      nxt    = RUN;
      change = 1'b1;
    end
  end

  // FSM and registered outputs; blank doubles as the blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      set_mode  <= 1'b0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      blank     <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      if (change) begin
        state    <= nxt;
        set_mode <= (nxt != RUN);
        blank    <= 1'b0;
      end else if (press_up || press_dn) begin
        inc_pulse <= press_up;
        dec_pulse <= press_dn;
        blank     <= 1'b0;
      end else if (in_set && event_clk1s) begin
        blank <= ~blank;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random buttons against a field-level model.
module tb_clock_set_ctrl;

  localparam int unsigned TO = 3;
`ifdef CLOCK_SET_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       event_clk1s = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_ok = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       set_mode;
  logic [2:0] field_sel;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       blank;

  int passes = 0;
  int total  = 0;

  // model: selected field index (0 = run), blink phase, idle seconds, last pulses
  int m_field = 0;
  int m_cnt   = 0;
  bit m_blank = 1'b0;
  bit m_inc   = 1'b0;
  bit m_dec   = 1'b0;

  clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk(clk), .rst(rst), .event_clk1s(event_clk1s),
    .btn_mode(btn_mode), .btn_ok(btn_ok), .btn_up(btn_up), .btn_down(btn_down),
    .set_mode(set_mode), .field_sel(field_sel),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic model(input bit r, ev, md, ok, up, dn);
    bit was_set;
    bit entered;
    bit anyb;
    was_set = (m_field != 0);
    entered = 1'b0;
    anyb    = md | ok | up | dn;
    m_inc   = 1'b0;
    m_dec   = 1'b0;
    if (r) begin
      m_field = 0; m_cnt = 0; m_blank = 1'b0;
    end else begin
      if (ok) begin
        if (was_set) begin m_field = 0; entered = 1'b1; end
      end else if (md) begin
        m_field = (m_field + 1) % 7; entered = 1'b1;
      end else if (TO_EN && was_set && ev && !up && !dn && (m_cnt + 1 >= int'(TO))) begin
        m_field = 0; entered = 1'b1;
      end else if (was_set && (up != dn)) begin
        m_inc = up; m_dec = dn; m_blank = 1'b0;
      end else if (was_set && ev) begin
        m_blank = !m_blank;
      end
      if (entered) m_blank = 1'b0;
      if (!was_set || entered || anyb) m_cnt = 0;
      else if (ev) m_cnt = m_cnt + 1;
    end
  endtask

  // one clock: drive, update model, sample 1 time unit after the edge
  task automatic step(input bit r, ev, md, ok, up, dn);
    rst = r; event_clk1s = ev; btn_mode = md; btn_ok = ok; btn_up = up; btn_down = dn;
    @(posedge clk);
    model(r, ev, md, ok, up, dn);
    #1;
    rst = 1'b0; event_clk1s = 1'b0; btn_mode = 1'b0; btn_ok = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0;
    chk("set_mode", 8'(set_mode), 8'(m_field != 0));
    chk("field_sel", 8'(field_sel), 8'(m_field));
    chk("inc_pulse", 8'(inc_pulse), 8'(m_inc));
    chk("dec_pulse", 8'(dec_pulse), 8'(m_dec));
    chk("blank", 8'(blank), 8'(m_blank));
  endtask

  task automatic goto_field(input int f);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < f; i++) step(0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    #1;
    // reset state
    step(1, 0, 0, 0, 0, 0);
    chk("rst_field", 8'(field_sel), 8'd0);
    chk("rst_blank", 8'(blank), 8'd0);

    // enter set mode, then walk all fields back to run
    step(0, 0, 1, 0, 0, 0);
    chk("enter_field", 8'(field_sel), 8'd1);
    chk("enter_set_mode", 8'(set_mode), 8'd1);
    chk("enter_blank", 8'(blank), 8'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0);
    chk("wrap_field", 8'(field_sel), 8'd0);
    chk("wrap_set_mode", 8'(set_mode), 8'd0);

    // SET_MIN: up, gap, down, then both together
    goto_field(2);
    step(0, 0, 0, 0, 1, 0);
    chk("min_inc", 8'(inc_pulse), 8'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("min_inc_once", 8'(inc_pulse), 8'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("min_dec", 8'(dec_pulse), 8'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("min_dec_once", 8'(dec_pulse), 8'd0);
    step(0, 0, 0, 0, 1, 1);
    chk("both_inc", 8'(inc_pulse), 8'd0);
    chk("both_dec", 8'(dec_pulse), 8'd0);

    // SET_HOUR blink sequence, then a press coinciding with a second tick
    goto_field(3);
    step(0, 1, 0, 0, 0, 0);
    chk("blink1", 8'(blank), 8'd1);
    step(0, 1, 0, 0, 0, 0);
    chk("blink2", 8'(blank), 8'd0);
    step(0, 1, 0, 0, 0, 0);
    chk("blink3", 8'(blank), 8'd1);
    step(0, 1, 0, 0, 1, 0);
    chk("press_tick_blank", 8'(blank), 8'd0);
    chk("press_tick_inc", 8'(inc_pulse), 8'd1);

    // ok beats up in SET_DAY; up in run is ignored
    goto_field(4);
    step(0, 0, 0, 1, 1, 0);
    chk("ok_run", 8'(field_sel), 8'd0);
    chk("ok_no_inc", 8'(inc_pulse), 8'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("run_no_inc", 8'(inc_pulse), 8'd0);

    // idle seconds in SET_YEAR
    goto_field(6);
    if (TO_EN) begin
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
      chk("timeout_run", 8'(field_sel), 8'd0);
      goto_field(6);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("timeout_restart", 8'(field_sel), 8'd6);
    end else begin
      for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 0, 0);
      chk("no_timeout", 8'(field_sel), 8'd6);
    end

    // reset mid-edit with a pending up press
    goto_field(5);
    step(1, 0, 0, 0, 1, 0);
    chk("rst_edit_out", 8'({set_mode, field_sel, inc_pulse, dec_pulse, blank}), 8'd0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
